mnist_frame_loader: RTL and testbench

- Upstream feeder for the MNIST accelerator core: accepts a 784-pixel frame as an 8-bit valid/ready stream and assembles it into the packed 6272-bit image bus.
- Drives the accelerator start, waits for done with a timeout, then returns the predicted digit on a result valid/ready handshake.
- Sits between the host/UART byte source and the accelerator core, replacing the fixed ROM test image.

---
 rtl/mnist_frame_loader.sv | 175 +++++++++++++++++
 tb/tb_mnist_frame_loader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_loader.sv
// Streams a 784-pixel MNIST frame into a packed image bus, runs the accelerator and returns its digit.
// Optional build macro MNIST_PIXEL_HALVE_EN stores each pixel as s_pix >> 1 (range 0..127).
module mnist_frame_loader #(
    parameter int IMG_SIZE  = 784,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_pix,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [IMG_SIZE*8-1:0] img_data,
    output logic                  accel_start,
    input  logic                  accel_done,
    input  logic [3:0]            accel_digit,
    output logic [3:0]            res_digit,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  err_len,
    output logic                  err_to
);

    localparam int PCW  = $clog2(IMG_SIZE);
    localparam int WCW  = $clog2(TIMEOUT);
    localparam int SCW  = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int IDXW = $clog2(IMG_SIZE * 8);

    localparam logic [PCW-1:0] PIX_LAST   = PCW'(IMG_SIZE - 1);
    localparam logic [WCW-1:0] TO_LAST    = WCW'(TIMEOUT - 1);
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t                state_q;
    logic [PCW-1:0]        pix_cnt_q;
    logic [WCW-1:0]        wait_cnt_q;
    logic [SCW-1:0]        start_cnt_q;
    logic [IMG_SIZE*8-1:0] img_q;
    logic                  s_ready_q;
    logic                  accel_start_q;
    logic                  res_valid_q;
    logic [3:0]            res_digit_q;
    logic                  err_len_q;
    logic                  err_to_q;

    logic [7:0]            pix_d;
    logic                  beat_d;
    logic [IDXW-1:0]       wr_idx_d;

`ifdef MNIST_PIXEL_HALVE_EN
    assign pix_d = {1'b0, s_pix[7:1]};
`else
    assign pix_d = s_pix;
`endif

    assign beat_d   = s_valid && s_ready_q;
    assign wr_idx_d = IDXW'({pix_cnt_q, 3'b000});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            start_cnt_q   <= '0;
            img_q         <= '0;
            s_ready_q     <= 1'b0;
            accel_start_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_digit_q   <= 4'hF;
            err_len_q     <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            // s_ready_q is only ever high in IDLE/LOAD, so a beat never lands outside them
            if (beat_d) begin
                img_q[wr_idx_d +: 8] <= pix_d;
            end

            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (beat_d) begin
                        err_to_q <= 1'b0;
                        if (s_last) begin
                            err_len_q <= 1'b1;
                            pix_cnt_q <= '0;
                        end else begin
                            err_len_q <= 1'b0;
                            pix_cnt_q <= PCW'(1);
                            state_q   <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (beat_d) begin
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_q     <= '0;
                            s_ready_q     <= 1'b0;
                            accel_start_q <= 1'b1;
                            start_cnt_q   <= '0;
                            state_q       <= ST_START;
                            if (!s_last) begin
                                err_len_q <= 1'b1;
                            end
                        end else if (s_last) begin
                            err_len_q <= 1'b1;
                            pix_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                    end
                end

                ST_START: begin
                    if (start_cnt_q == START_LAST) begin
                        accel_start_q <= 1'b0;
                        wait_cnt_q    <= '0;
                        state_q       <= ST_WAIT;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end

                ST_WAIT: begin
                    // Leaving WAIT on the first sampled done makes a level done count once
                    if (accel_done) begin
                        res_digit_q <= accel_digit;
                        state_q     <= ST_RESULT;
                    end else if (wait_cnt_q == TO_LAST) begin
                        err_to_q    <= 1'b1;
                        res_digit_q <= 4'hF;
                        s_ready_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                ST_RESULT: begin
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                    end else if (res_ready) begin
                        res_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign img_data    = img_q;
    assign accel_start = accel_start_q;
    assign res_digit   = res_digit_q;
    assign res_valid   = res_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_len     = err_len_q;
    assign err_to      = err_to_q;

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Self-checking bench for mnist_frame_loader: random frames against an array image model and a
// simple accelerator responder.
module tb_mnist_frame_loader;

    localparam int IMG = 784;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     s_pix;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [IMG*8-1:0] img_data;
    logic           accel_start;
    logic           accel_done;
    logic [3:0]     accel_digit;
    logic [3:0]     res_digit;
    logic           res_valid;
    logic           res_ready;
    logic           busy;
    logic           err_len;
    logic           err_to;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_img [IMG];

    mnist_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_pix       (s_pix),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .img_data    (img_data),
        .accel_start (accel_start),
        .accel_done  (accel_done),
        .accel_digit (accel_digit),
        .res_digit   (res_digit),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .err_len     (err_len),
        .err_to      (err_to)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] stored(input logic [7:0] b);
`ifdef MNIST_PIXEL_HALVE_EN
        return b >> 1;
`else
        return b;
`endif
    endfunction

    // Number of pixels whose bus slice disagrees with the model; first_bad gets the lowest index.
    function automatic int count_bad(output int first_bad);
        int n;
        n = 0;
        first_bad = -1;
        for (int k = 0; k < IMG; k++) begin
            if (img_data[k*8 +: 8] !== exp_img[k]) begin
                if (first_bad < 0) first_bad = k;
                n++;
            end
        end
        return n;
    endfunction

    // mode 0: ramp k mod 256, 1: random, 2: pixel 0 = 0xFF then random
    task automatic send_frame(input int n, input int last_at, input int mode, output bit ok);
        logic [7:0] v;
        int t;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (mode == 0)                 v = 8'(k % 256);
            else if (mode == 2 && k == 0)  v = 8'hFF;
            else                           v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_pix   = v;
            s_valid = 1'b1;
            s_last  = (k == last_at);
            t = 0;
            while (s_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (s_ready !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL send_beat k=%0d s_ready=%b required=1", k, s_ready);
                ok = 1'b0;
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge clk);
            exp_img[k] = stored(v);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic measure_start(output int len);
        len = 0;
        while (accel_start === 1'b1 && len < 20) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic accel_respond(input int delay, input logic [3:0] d, input bit level, output bit seen);
        int t;
        repeat (delay) @(negedge clk);
        accel_done  = 1'b1;
        accel_digit = d;
        @(negedge clk);
        if (!level) accel_done = 1'b0;
        t = 0;
        while (res_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        accel_done  = 1'b0;
        accel_digit = 4'($urandom);
        seen = (res_valid === 1'b1);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_pix = '0; s_valid = 1'b0; s_last = 1'b0;
        accel_done = 1'b0; accel_digit = '0; res_ready = 1'b0;
        for (int k = 0; k < IMG; k++) exp_img[k] = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || img_data !== '0 || accel_start !== 1'b0 || res_digit !== 4'hF ||
            res_valid !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0 || err_to !== 1'b0)
            begin failures++; $display("FAIL reset_state s_ready=%b start=%b digit=%h valid=%b busy=%b el=%b et=%b required 0,0,F,0,0,0,0",
                s_ready, accel_start, res_digit, res_valid, busy, err_len, err_to); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready s_ready=%b required=1", s_ready); end
    endtask

    task automatic test_full_frame();
        bit ok, seen;
        int len, bad, fb;
        send_frame(IMG, IMG-1, 0, ok);
        checks++;
        if (accel_start !== 1'b1) begin failures++; $display("FAIL full_start_latency accel_start=%b required=1", accel_start); end
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin failures++; $display("FAIL full_busy_start busy=%b s_ready=%b required 1,0", busy, s_ready); end
        measure_start(len);
        checks++;
        if (len !== 2) begin failures++; $display("FAIL full_start_len got=%0d required=2", len); end
        bad = count_bad(fb);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL full_image bad=%0d first=%0d required 0", bad, fb); end
        accel_respond(100, 4'd6, 1'b0, seen);
        checks++;
        if (res_valid !== 1'b1 || res_digit !== 4'd6 || busy !== 1'b1)
            begin failures++; $display("FAIL full_result valid=%b digit=%0d busy=%b required 1,6,1", res_valid, res_digit, busy); end
        accept_result();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || res_digit !== 4'd6 || err_len !== 1'b0)
            begin failures++; $display("FAIL full_accept valid=%b busy=%b s_ready=%b digit=%0d err_len=%b required 0,0,1,6,0",
                res_valid, busy, s_ready, res_digit, err_len); end
        $display("full frame ramp: start_len=%0d digit=%0d", len, res_digit);
    endtask

    task automatic test_random_frames();
        bit ok, seen, level;
        int len, bad, fb, delay;
        logic [3:0] d;
        for (int it = 0; it < 2; it++) begin
            d     = 4'($urandom_range(0, 9));
            delay = $urandom_range(1, 300);
            level = 1'($urandom_range(0, 1));
            send_frame(IMG, IMG-1, 1, ok);
            measure_start(len);
            checks++;
            if (len !== 2) begin failures++; $display("FAIL rand_start_len it=%0d got=%0d required=2", it, len); end
            bad = count_bad(fb);
            checks++;
            if (bad !== 0) begin failures++; $display("FAIL rand_image it=%0d bad=%0d first=%0d required 0", it, bad, fb); end
            accel_respond(delay, d, level, seen);
            checks++;
            if (res_valid !== 1'b1 || res_digit !== d)
                begin failures++; $display("FAIL rand_result it=%0d valid=%b digit=%0d required 1,%0d", it, res_valid, res_digit, d); end
            accept_result();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0)
                begin failures++; $display("FAIL rand_accept it=%0d valid=%b busy=%b required 0,0", it, res_valid, busy); end
            $display("random frame %0d: delay=%0d level=%0b digit=%0d", it, delay, level, res_digit);
        end
    endtask

    task automatic test_early_last();
        bit ok, seen, started;
        int len, bad, fb;
        send_frame(301, 300, 1, ok);
        checks++;
        if (err_len !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || accel_start !== 1'b0)
            begin failures++; $display("FAIL early_state err_len=%b busy=%b s_ready=%b start=%b required 1,0,1,0",
                err_len, busy, s_ready, accel_start); end
        started = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (accel_start === 1'b1) started = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (started !== 1'b0) begin failures++; $display("FAIL early_no_start saw_start=%b required=0", started); end
        bad = count_bad(fb);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL early_partial_image bad=%0d first=%0d required 0", bad, fb); end
        send_frame(IMG, IMG-1, 1, ok);
        checks++;
        if (err_len !== 1'b0 || accel_start !== 1'b1)
            begin failures++; $display("FAIL early_recover err_len=%b start=%b required 0,1", err_len, accel_start); end
        measure_start(len);
        accel_respond(20, 4'd3, 1'b1, seen);
        checks++;
        if (res_valid !== 1'b1 || res_digit !== 4'd3)
            begin failures++; $display("FAIL early_recover_result valid=%b digit=%0d required 1,3", res_valid, res_digit); end
        accept_result();
        $display("early s_last at pixel 300: err_len flagged, recovery digit=%0d", res_digit);
    endtask

    task automatic test_no_last();
        bit ok, seen;
        int len, bad, fb;
        send_frame(IMG, -1, 1, ok);
        checks++;
        if (accel_start !== 1'b1 || err_len !== 1'b1)
            begin failures++; $display("FAIL nolast_start start=%b err_len=%b required 1,1", accel_start, err_len); end
        measure_start(len);
        checks++;
        if (len !== 2) begin failures++; $display("FAIL nolast_start_len got=%0d required=2", len); end
        bad = count_bad(fb);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL nolast_image bad=%0d first=%0d required 0", bad, fb); end
        accel_respond(37, 4'd9, 1'b0, seen);
        checks++;
        if (res_valid !== 1'b1 || res_digit !== 4'd9)
            begin failures++; $display("FAIL nolast_result valid=%b digit=%0d required 1,9", res_valid, res_digit); end
        accept_result();
        checks++;
        if (err_len !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL nolast_sticky err_len=%b busy=%b required 1,0", err_len, busy); end
        $display("frame without s_last: err_len=%b digit=%0d", err_len, res_digit);
    endtask

    task automatic test_timeout();
        bit ok;
        int len, n;
        send_frame(IMG, IMG-1, 1, ok);
        measure_start(len);
        n = 0;
        while (err_to !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4096) begin failures++; $display("FAIL timeout_cycles got=%0d required=4096", n); end
        checks++;
        if (err_to !== 1'b1 || res_digit !== 4'hF || res_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL timeout_state err_to=%b digit=%h valid=%b s_ready=%b busy=%b required 1,F,0,1,0",
                err_to, res_digit, res_valid, s_ready, busy); end
        $display("timeout: wait cycles=%0d err_to=%b", n, err_to);
    endtask

    task automatic test_result_hold();
        bit ok, seen;
        int len, bad, fb, hold_bad;
        logic [3:0] d;
        d = 4'($urandom_range(0, 9));
        send_frame(IMG, IMG-1, 1, ok);
        checks++;
        if (err_to !== 1'b0) begin failures++; $display("FAIL hold_clear_err_to err_to=%b required=0", err_to); end
        measure_start(len);
        accel_respond($urandom_range(1, 50), d, 1'b1, seen);
        hold_bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (res_valid !== 1'b1 || res_digit !== d) hold_bad++;
            if (c == 10) begin
                s_pix = 8'($urandom_range(0, 255));
                s_valid = 1'b1;
                checks++;
                if (s_ready !== 1'b0) begin failures++; $display("FAIL hold_s_ready s_ready=%b required=0", s_ready); end
            end
            if (c == 13) s_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (hold_bad !== 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d required 0 (digit %0d)", hold_bad, d); end
        bad = count_bad(fb);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL hold_not_consumed bad=%0d first=%0d required 0", bad, fb); end
        accept_result();
        checks++;
        if (res_valid !== 1'b0 || res_digit !== d)
            begin failures++; $display("FAIL hold_accept valid=%b digit=%0d required 0,%0d", res_valid, res_digit, d); end
        $display("result held 50 cycles: digit=%0d", d);

        d = 4'($urandom_range(0, 9));
        send_frame(IMG, IMG-1, 1, ok);
        measure_start(len);
        accel_respond(5, d, 1'b0, seen);
        for (int c = 0; c < 20; c++) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_digit !== d)
            begin failures++; $display("FAIL prereset_result valid=%b digit=%0d required 1,%0d", res_valid, res_digit, d); end
        #2 rst = 1'b0;
        for (int k = 0; k < IMG; k++) exp_img[k] = 8'h00;
        #1;
        checks++;
        if (s_ready !== 1'b0 || img_data !== '0 || accel_start !== 1'b0 || res_digit !== 4'hF ||
            res_valid !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0 || err_to !== 1'b0)
            begin failures++; $display("FAIL async_reset s_ready=%b start=%b digit=%h valid=%b busy=%b el=%b et=%b required 0,0,F,0,0,0,0",
                s_ready, accel_start, res_digit, res_valid, busy, err_len, err_to); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL reset_recover s_ready=%b busy=%b required 1,0", s_ready, busy); end
        $display("reset during RESULT hold: outputs returned to reset values");
    endtask

    task automatic test_halve();
        bit ok, seen;
        int len, bad, fb;
        logic [7:0] want;
`ifdef MNIST_PIXEL_HALVE_EN
        want = 8'h7F;
`else
        want = 8'hFF;
`endif
        send_frame(IMG, IMG-1, 2, ok);
        checks++;
        if (img_data[7:0] !== want) begin failures++; $display("FAIL halve_pixel0 got=%h required=%h", img_data[7:0], want); end
        bad = count_bad(fb);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL halve_image bad=%0d first=%0d required 0", bad, fb); end
        measure_start(len);
        accel_respond(10, 4'd1, 1'b0, seen);
        checks++;
        if (res_valid !== 1'b1 || res_digit !== 4'd1)
            begin failures++; $display("FAIL halve_result valid=%b digit=%0d required 1,1", res_valid, res_digit); end
        accept_result();
        $display("pixel 0xFF stored as %h", img_data[7:0]);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_frames();
        test_early_last();
        test_no_last();
        test_timeout();
        test_result_hold();
        test_halve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
